// File: rtl/logic_gates_two.sv
// Registered two-input bitwise logic unit: AND, OR of iA/iB and NOT of iA,
// each captured in a WIDTH-bit register with a synchronous active-low reset.
module logic_gates_two #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             iClk,
   input  logic             iRst_n,
   input  logic [WIDTH-1:0] iA,
   input  logic [WIDTH-1:0] iB,
   output logic [WIDTH-1:0] oAnd,
   output logic [WIDTH-1:0] oOr,
   output logic [WIDTH-1:0] oNot
);

   typedef struct packed {
      logic [WIDTH-1:0] and_r;
      logic [WIDTH-1:0] or_r;
      logic [WIDTH-1:0] not_r;
   } gates_t;

   gates_t gates_d;
   gates_t gates_q;

   always_comb begin
      gates_d       = '0;
      gates_d.and_r = iA & iB;
      gates_d.or_r  = iA | iB;
      gates_d.not_r = ~iA;
   end

   // NOTE: reset lives inside the clocked branch so it only acts on a rising
   // edge; non-blocking assignments keep every flop sampling pre-edge values.
   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         gates_q <= '0;
      end else begin
         gates_q <= gates_d;
      end
   end

   assign oAnd = gates_q.and_r;
   assign oOr  = gates_q.or_r;
   assign oNot = gates_q.not_r;

endmodule

// File: tb/tb_logic_gates_two.sv
// Self-checking bench for logic_gates_two: directed plan plus random stimulus,
// checked every cycle against a per-bit arithmetic model at both widths.
module tb_logic_gates_two;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       a1, b1;
   logic [7:0] a8, b8;
   logic       and1, or1, not1;
   logic [7:0] and8, or8, not8;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   logic_gates_two #(.WIDTH(1)) u_dut1 (
      .iClk(clk), .iRst_n(rst_n), .iA(a1), .iB(b1),
      .oAnd(and1), .oOr(or1), .oNot(not1)
   );

   logic_gates_two #(.WIDTH(8)) u_dut8 (
      .iClk(clk), .iRst_n(rst_n), .iA(a8), .iB(b8),
      .oAnd(and8), .oOr(or8), .oNot(not8)
   );

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Model: per bit, AND is a product, OR is "sum nonzero", NOT is 1 - a.
   logic       model_valid = 1'b0;
   logic [7:0] m_and8, m_or8, m_not8;
   logic       m_and1, m_or1, m_not1;

   always @(posedge clk) begin
      logic [7:0] ta, to, tn;
      if (!rst_n) begin
         model_valid <= 1'b1;
         {m_and1, m_or1, m_not1} <= '0;
         {m_and8, m_or8, m_not8} <= '0;
      end else if (model_valid) begin
         for (int i = 0; i < 8; i++) begin
            int x, y;
            x = int'(a8[i]);
            y = int'(b8[i]);
            ta[i] = ((x * y) == 1);
            to[i] = ((x + y) > 0);
            tn[i] = ((1 - x) == 1);
         end
         m_and8 <= ta;
         m_or8  <= to;
         m_not8 <= tn;
         m_and1 <= ((int'(a1) * int'(b1)) == 1);
         m_or1  <= ((int'(a1) + int'(b1)) > 0);
         m_not1 <= ((1 - int'(a1)) == 1);
      end
   end

   always @(negedge clk) begin
      if (model_valid) begin
         check("and1", 8'(and1), 8'(m_and1));
         check("or1",  8'(or1),  8'(m_or1));
         check("not1", 8'(not1), 8'(m_not1));
         check("and8", and8, m_and8);
         check("or8",  or8,  m_or8);
         check("not8", not8, m_not8);
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic check1(input string name, input logic [2:0] exp);
      check(name, 8'({and1, or1, not1}), 8'(exp));
   endtask

   logic [1:0] tt_in  [5] = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b00};
   logic [2:0] tt_out [5] = '{3'b001, 3'b010, 3'b011, 3'b110, 3'b001};
   logic [1:0] bb_in  [4] = '{2'b00, 2'b11, 2'b01, 2'b10};
   logic [2:0] bb_out [4] = '{3'b001, 3'b110, 3'b011, 3'b010};

   initial begin
      rst_n = 1'b0;
      a1 = 1'b1; b1 = 1'b1;
      a8 = 8'hFF; b8 = 8'hFF;
      #2;

      // Reset held for two edges with all-ones inputs.
      for (int i = 0; i < 2; i++) begin
         step();
         check1("reset_w1", 3'b000);
         check("reset_w8", {and8 | or8 | not8}, 8'h00);
      end

      // Truth table sweep, each pattern held four cycles.
      rst_n = 1'b1;
      for (int p = 0; p < 5; p++) begin
         {a1, b1} = tt_in[p];
         step();
         check1("truth_table", tt_out[p]);
         for (int k = 0; k < 3; k++) step();
      end

      // Latency: iA rises between edges and must wait for the next edge.
      a1 = 1'b0; b1 = 1'b1;
      step();
      #1 a1 = 1'b1;
      #1 check1("latency_hold", 3'b011);
      step();
      check1("latency_update", 3'b110);

      // Bitwise width check.
      a8 = 8'hF0; b8 = 8'h3C;
      step();
      check("width_and", and8, 8'h30);
      check("width_or",  or8,  8'hFC);
      check("width_not", not8, 8'h0F);

      // Mid-stream reset pulse: no effect until the edge, then clears all.
      a8 = 8'hAA; b8 = 8'h55;
      step();
      rst_n = 1'b0;
      #1 check("rst_sync_hold_or", or8, 8'hFF);
      check("rst_sync_hold_not", not8, 8'h55);
      step();
      check("rst_mid_and", and8, 8'h00);
      check("rst_mid_or",  or8,  8'h00);
      check("rst_mid_not", not8, 8'h00);
      rst_n = 1'b1;
      step();
      check("rst_rel_and", and8, 8'h00);
      check("rst_rel_or",  or8,  8'hFF);
      check("rst_rel_not", not8, 8'h55);

      // Back-to-back changes every cycle.
      for (int p = 0; p < 4; p++) begin
         {a1, b1} = bb_in[p];
         step();
         check1("back_to_back", bb_out[p]);
      end

      // Random traffic with occasional reset pulses.
      for (int n = 0; n < 400; n++) begin
         a1    = 1'($urandom);
         b1    = 1'($urandom);
         a8    = 8'($urandom);
         b8    = 8'($urandom);
         rst_n = ($urandom_range(0, 15) != 0);
         step();
      end

      rst_n = 1'b1;
      step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/logic_gates_two.md
# logic_gates_two

Registered two-input bitwise logic unit producing AND, OR and NOT results from two operand buses. Sits as a leaf utility block in the datapath wherever a clocked, glitch-free gate result is needed. Outputs are captured in flip-flops, so downstream logic sees stable values aligned to the clock.

## Interface

Parameters:
- WIDTH, default 1: bit width of both operands and all three results.

Ports:
- iClk  input  1  single system clock; all state updates on its rising edge.
- iRst_n  input  1  reset, synchronous and active-low; sampled on the rising edge of iClk.
- iA  input  WIDTH  operand A.
- iB  input  WIDTH  operand B.
- oAnd  output  WIDTH  registered bitwise AND of iA and iB.
- oOr  output  WIDTH  registered bitwise OR of iA and iB.
- oNot  output  WIDTH  registered bitwise inversion of iA. iB does not affect it.

## Operation

- Per bit i on every rising edge of iClk with iRst_n = 1:
  - oAnd[i] <= iA[i] & iB[i]
  - oOr[i] <= iA[i] | iB[i]
  - oNot[i] <= ~iA[i]
- All operations are purely bitwise. There is no carry, no cross-bit interaction and no width extension, and every result is exactly WIDTH bits.
- No enable and no handshake. Outputs update on every cycle while not in reset.
- No internal state other than the three output registers (3 × WIDTH flops).
- X/Z on inputs: no special handling required. Results follow standard Verilog operator semantics.

## Timing

- Latency is 1 cycle. Inputs sampled at rising edge N appear on the outputs immediately after edge N and are held until edge N+1.
- Throughput is one new result per cycle. Back-to-back input changes each produce their own result.
- Inputs changing between edges have no effect until the next rising edge. Outputs never change between edges.
- Reset, with iRst_n = 0 sampled at a rising edge:
  - oAnd = 0, oOr = 0 and oNot = 0 (all bits), including oNot regardless of iA.
  - Reset takes priority over input evaluation.
- Reset release: on the first edge with iRst_n = 1, outputs take the gate results of the inputs present at that edge.
- Reset asserted in the middle of operation: it takes effect at the next rising edge only. Outputs keep their previous values until that edge. An asynchronous response is forbidden.
- Before the first clock edge, output values are undefined. The bench must apply reset for at least one edge.

## Test plan

- Reset check: with WIDTH=1, hold iRst_n=0 for 2 edges while iA=1, iB=1. Required: oAnd=0, oOr=0, oNot=0 after each edge.
- Truth table sweep: with WIDTH=1, after reset, apply (iA,iB) = 00, 10, 01, 11, 00, each held 4 cycles. Required (oAnd, oOr, oNot) one edge after each change: (0,0,1), (0,1,0), (0,1,1), (1,1,0), (0,0,1).
- Latency check: change iA from 0 to 1 midway between edges with iB=1. Required: outputs unchanged until the next edge, then oAnd=1, oOr=1, oNot=0.
- Bitwise width check: with WIDTH=8, apply iA=8'hF0, iB=8'h3C. Required one edge later: oAnd=8'h30, oOr=8'hFC, oNot=8'h0F.
- Reset mid-stream: with WIDTH=8, pulse iRst_n low for exactly one edge while iA=8'hAA, iB=8'h55. Required: all outputs 8'h00 after that edge. On the next edge with iRst_n=1: oAnd=8'h00, oOr=8'hFF, oNot=8'h55.
- Back-to-back throughput: with WIDTH=1, change inputs every cycle through 00→11→01→10. Required: each output sequence matches the truth table, delayed by exactly one cycle, with no dropped or repeated values.
